// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int OVS_DEF       = 16;
    localparam int DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every CLK_DIV clocks, with synchronous
// clear so the tick phase can be realigned to an incoming edge.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes the line, samples an 8N1-style frame at
// mid-bit, and hands bytes out through a valid/ready holding register.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 27,
    parameter int OVS       = OVS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int OS_W  = $clog2(OVS);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVS / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic                 rxd_m, rxd_s;
    logic [OS_W-1:0]      os_cnt, os_cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 div_clear, tick;
    logic                 good_evt, ferr_evt;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .tick  (tick)
    );

    assign o_busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        div_clear = 1'b0;
        good_evt  = 1'b0;
        ferr_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n   = START;
                    os_cnt_n  = '0;
                    bit_cnt_n = '0;
                    div_clear = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (os_cnt == OS_MID) begin
                        os_cnt_n = '0;
                        state_n  = rxd_s ? IDLE : DATA;
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt_n  = '0;
                        shreg_n   = {rxd_s, shreg[DATA_BITS-1:1]};
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) state_n = STOP;
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt_n = '0;
                        if (rxd_s) begin
                            good_evt = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            ferr_evt = 1'b1;
                            state_n  = WAIT_HIGH;
                        end
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
            end
            // A held-low line (break) must return high before a new start is accepted.
            WAIT_HIGH: begin
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rxd_m       <= 1'b1;
            rxd_s       <= 1'b1;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_n;
            rxd_m       <= i_rxd;
            rxd_s       <= rxd_m;
            os_cnt      <= os_cnt_n;
            bit_cnt     <= bit_cnt_n;
            o_frame_err <= ferr_evt;
            o_overrun   <= good_evt && o_rx_valid && !i_rx_ready;
            // A byte accepted this cycle frees the holding register for the new one.
            if (good_evt && (!o_rx_valid || i_rx_ready)) begin
                o_rx_data  <= shreg;
                o_rx_valid <= 1'b1;
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART serial link. Generates the oversampling baud tick and qualifies the start bit. Sequences mid-bit sampling of an 8N1 frame and delivers each received byte through a valid/ready handshake. Sits between the raw i_rxd pin and the consumer, typically a FIFO or a register block. Flags framing errors and overruns so the consumer can drop bad bytes.

Parameters:
CLK_DIV, 27, clk cycles per oversample tick (clk_freq / (baud * OVS)); legal range 2..65535
OVS, 16, oversample ticks per bit; must be even, minimum 4
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_rxd  input  1  asynchronous serial line, idle high
o_rx_data  output  DATA_BITS  received byte, stable while o_rx_valid=1
o_rx_valid  output  1  o_rx_data holds an unconsumed byte
i_rx_ready  input  1  consumer accepts the byte when o_rx_valid && i_rx_ready
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: a good frame was lost because the holding register was full
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high) forces:
  - state to IDLE
  - 2-flop synchronizer to 1
  - all counters to 0
  - o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_overrun=0, o_busy=0
- Reset asserted mid-frame abandons the frame; no pulses are generated.
- i_rxd passes through a 2-flop synchronizer giving rxd_s. All decisions use rxd_s only.
- Tick divider:
  - div_cnt counts 0..CLK_DIV-1.
  - tick=1 for one clk when div_cnt==CLK_DIV-1, then div_cnt wraps to 0.
  - div_cnt and os_cnt clear on the IDLE->START transition, so ticks align to the falling edge.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxd_s==0 -> START; os_cnt=0, bit_cnt=0.
  - START: os_cnt increments on each tick. On the tick where os_cnt==OVS/2-1 (mid start bit):
    - rxd_s==0 -> DATA, os_cnt=0.
    - rxd_s==1 -> IDLE (false start, glitch rejected; no error flag).
  - DATA: os_cnt increments on each tick. On the tick where os_cnt==OVS-1:
    - shift rxd_s into the shift register MSB side (shift right), so after DATA_BITS samples bit0 is the first bit received;
    - bit_cnt++, os_cnt=0;
    - after the DATA_BITS-th sample -> STOP.
  - STOP: on the tick where os_cnt==OVS-1, sample rxd_s:
    - 1 -> good frame, go to IDLE;
    - 0 -> o_frame_err pulses, data is discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s==1, then -> IDLE. This keeps a break condition from retriggering the receiver.
- Output handshake:
  - A good frame loads o_rx_data and sets o_rx_valid on the clk edge after the stop-sample tick.
  - o_rx_valid clears on the edge after o_rx_valid && i_rx_ready.
  - Good frame completes while o_rx_valid=1 and i_rx_ready=0: new byte dropped, old byte kept, o_overrun pulses one cycle.
  - Good frame completes in the same cycle as an accept (valid&&ready): new byte loads, o_rx_valid stays 1, no overrun.
  - A frame error never modifies o_rx_data or o_rx_valid.
- Latency: falling edge on i_rxd to o_rx_valid is 2 (sync) + (OVS/2 + OVS*(DATA_BITS+1))*CLK_DIV + 1 clk, within ±1 tick of divider phase.
- o_busy is a combinational decode of state != IDLE.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP, WAIT_HIGH), 3-bit encoding;
  - default constants OVS_DEF=16, DATA_BITS_DEF=8.
- One sub-module, uart_baud_tick: the div_cnt divider with a synchronous clear input and a tick output, parameterised by CLK_DIV. It is reused by the TX side.

Test Plan:
(All scenarios use CLK_DIV=4, OVS=16, giving 64 clk per bit.)
- Send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) with i_rx_ready=1 -> o_rx_valid pulses one cycle with o_rx_data=0xA5; o_frame_err=0; o_overrun=0.
- Hold i_rxd low for 20 clk only (glitch) -> returns to IDLE before DATA; o_rx_valid, o_frame_err, o_busy=0 afterwards.
- Send 0x3C with stop bit low, then line high -> o_frame_err pulses once; o_rx_valid stays 0; o_rx_data unchanged.
- i_rx_ready=0, send 0x11 then 0x22 -> o_rx_data=0x11, o_rx_valid=1, o_overrun pulses once at the end of the second frame. Then ready=1 for one clk -> o_rx_valid=0.
- Assert i_rx_ready in exactly the cycle the second frame completes -> o_rx_data=0x22, o_rx_valid held at 1, no overrun.
- Assert reset during bit 4 of a frame -> next clk: o_busy=0, all outputs 0. A following frame 0x5A is received correctly.
